// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, default header layout
// and the one-hot port encoding used between routing stages and arbiters.
package noc_pkg;

   localparam int NUM_PORTS = 5;

   localparam int PORT_N  = 0;
   localparam int PORT_S  = 1;
   localparam int PORT_E  = 2;
   localparam int PORT_W  = 3;
   localparam int PORT_PE = 4;

   localparam int DEF_PKT_W    = 64;
   localparam int DEF_HOP_W    = 2;
   localparam int DEF_DIRX_BIT = 58;
   localparam int DEF_DIRY_BIT = 57;
   localparam int DEF_HOPX_LSB = 55;
   localparam int DEF_HOPY_LSB = 53;

   typedef logic [NUM_PORTS-1:0] port_oh_t;

   function automatic port_oh_t port_onehot(input int idx);
      return port_oh_t'(1) << idx;
   endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY dimension-order route decision: picks the output port from
// the header and consumes one hop from the dimension being travelled.
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int PKT_W    = DEF_PKT_W,
   parameter int HOP_W    = DEF_HOP_W,
   parameter int DIRX_BIT = DEF_DIRX_BIT,
   parameter int DIRY_BIT = DEF_DIRY_BIT,
   parameter int HOPX_LSB = DEF_HOPX_LSB,
   parameter int HOPY_LSB = DEF_HOPY_LSB
) (
   input  logic [PKT_W-1:0] hdr_in,
   output port_oh_t         port,
   output logic [PKT_W-1:0] hdr_out
);

   logic [HOP_W-1:0] hop_x;
   logic [HOP_W-1:0] hop_y;

   assign hop_x = hdr_in[HOPX_LSB +: HOP_W];
   assign hop_y = hdr_in[HOPY_LSB +: HOP_W];

   // X is exhausted before Y; a zero field is never decremented, so no underflow.
   always_comb begin
      port    = port_onehot(PORT_PE);
      hdr_out = hdr_in;
      if (hop_x != '0) begin
         port = hdr_in[DIRX_BIT] ? port_onehot(PORT_W) : port_onehot(PORT_E);
         hdr_out[HOPX_LSB +: HOP_W] = hop_x - HOP_W'(1);
      end else if (hop_y != '0) begin
         port = hdr_in[DIRY_BIT] ? port_onehot(PORT_S) : port_onehot(PORT_N);
         hdr_out[HOPY_LSB +: HOP_W] = hop_y - HOP_W'(1);
      end
   end

endmodule

// File: rtl/noc_route_unit_xy.sv
// Per-input routing stage: pops the input FIFO, routes at enqueue time, holds
// up to DEPTH routed packets and offers the head to the output arbiters.
module noc_route_unit_xy
   import noc_pkg::*;
#(
   parameter int PKT_W    = DEF_PKT_W,
   parameter int HOP_W    = DEF_HOP_W,
   parameter int DIRX_BIT = DEF_DIRX_BIT,
   parameter int DIRY_BIT = DEF_DIRY_BIT,
   parameter int HOPX_LSB = DEF_HOPX_LSB,
   parameter int HOPY_LSB = DEF_HOPY_LSB,
   parameter int IN_PORT  = PORT_N,
   parameter int DEPTH    = 2,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 empty,
   input  logic [PKT_W-1:0]     in_packet,
   output logic                 rd_en,
   input  logic [NUM_PORTS-1:0] out_ready,
   output logic [NUM_PORTS-1:0] out_req,
   output logic [PKT_W-1:0]     out_packet,
   output logic                 err_drop,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 busy
);

   localparam logic [1:0] DEPTH_C = 2'(DEPTH);
   localparam logic       LAST_IDX = 1'(DEPTH - 1);

   port_oh_t         route_port;
   logic [PKT_W-1:0] route_pkt;
   logic             is_uturn;
   logic             push;
   logic             drop;
   logic             deq;
   logic             head_valid;
   logic             prev_ptr;

   logic [PKT_W-1:0] pkt_q  [DEPTH];
   port_oh_t         port_q [DEPTH];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;

   xy_route_calc #(
      .PKT_W    (PKT_W),
      .HOP_W    (HOP_W),
      .DIRX_BIT (DIRX_BIT),
      .DIRY_BIT (DIRY_BIT),
      .HOPX_LSB (HOPX_LSB),
      .HOPY_LSB (HOPY_LSB)
   ) u_calc (
      .hdr_in  (in_packet),
      .port    (route_port),
      .hdr_out (route_pkt)
   );

   // A packet that would leave through the side it came in on is discarded;
   // the PE side is exempt so a node may deliver to itself.
   assign is_uturn = (IN_PORT != PORT_PE) && (route_port == port_onehot(IN_PORT));

   // Pop is gated by reset so the FIFO is never drained while the queue is held clear.
   assign rd_en = !reset && !empty && (count < DEPTH_C);
   assign push  = rd_en && !is_uturn;
   assign drop  = rd_en && is_uturn;

   assign head_valid = (count != 2'd0);
   assign busy       = head_valid;
   assign out_req    = head_valid ? port_q[rd_ptr] : '0;
   assign deq        = |(out_req & out_ready);

   // The slot behind the read pointer is the last packet handed out; it is not
   // rewritten while the queue is empty, so it keeps out_packet stable.
   assign prev_ptr   = (rd_ptr == 1'b0) ? LAST_IDX : rd_ptr - 1'b1;
   assign out_packet = head_valid ? pkt_q[rd_ptr] : pkt_q[prev_ptr];

   function automatic logic next_ptr(input logic p);
      return (p == LAST_IDX) ? 1'b0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pkt_q[i]  <= '0;
            port_q[i] <= '0;
         end
         wr_ptr <= 1'b0;
      end else if (push) begin
         pkt_q[wr_ptr]  <= route_pkt;
         port_q[wr_ptr] <= route_port;
         wr_ptr         <= next_ptr(wr_ptr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= 1'b0;
      end else if (deq) begin
         rd_ptr <= next_ptr(rd_ptr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 2'd0;
      end else begin
         case ({push, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_drop <= 1'b0;
         err_cnt  <= '0;
      end else begin
         err_drop <= drop;
         if (drop && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/noc_route_unit_xy.md
Name: noc_route_unit_xy

Overview:
- Parametrised per-input-port XY routing stage for the mesh router. One instance per router input (N/S/E/W/PE).
- Pops packets from the input FIFO, computes the output port at enqueue time, and decrements the consumed hop field in the header.
- Holds routed packets in a DEPTH-entry queue and presents them to the output arbiters with a req/ready handshake.
- Drops and counts U-turn packets instead of forwarding them; sustains one packet per cycle.

Parameters:
- PKT_W, 64: packet width.
- HOP_W, 2: width of each hop-count field.
- DIRX_BIT, 58: header bit for X direction; 0 = east, 1 = west.
- DIRY_BIT, 57: header bit for Y direction; 0 = north, 1 = south.
- HOPX_LSB, 55: LSB of the hop_x field.
- HOPY_LSB, 53: LSB of the hop_y field.
- IN_PORT, 0: this instance's input side; 0 = N, 1 = S, 2 = E, 3 = W, 4 = PE.
- DEPTH, 2: holding-queue entries; legal values 1 or 2.
- CNT_W, 8: width of the error counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous reset, active-high.
- empty, input, 1: input FIFO empty. FIFO is first-word-fall-through.
- in_packet, input, PKT_W: FIFO head data; valid whenever empty = 0.
- rd_en, output, 1: FIFO pop strobe.
- out_ready, input, 5: per-output ready (arbiter grant and downstream not full). Bit order [0] N, [1] S, [2] E, [3] W, [4] PE.
- out_req, output, 5: one-hot request for the queue head.
- out_packet, output, PKT_W: queue-head packet with updated header.
- err_drop, output, 1: one-cycle pulse when a packet is dropped.
- err_cnt, output, CNT_W: saturating count of dropped packets.
- busy, output, 1: queue non-empty.

Behaviour:
- Reset (asynchronous, immediate):
  - Queue cleared; all entries invalidated.
  - out_req = 0, rd_en = 0, err_drop = 0, err_cnt = 0, busy = 0, out_packet = 0.
  - A packet in flight is lost; the FIFO is not popped during reset.
- Pop rule: rd_en = !empty && (count < DEPTH). Combinational; does not depend on out_ready. The pop is committed on the clock edge where rd_en = 1.
- Route computation (combinational on in_packet at pop):
  - hop_x != 0: route E if dir_x = 0, W if dir_x = 1; hop_x <= hop_x - 1.
  - Otherwise, hop_y != 0: route N if dir_y = 0, S if dir_y = 1; hop_y <= hop_y - 1.
  - Otherwise route PE; header unchanged.
  - Subtraction is HOP_W bits wide and never underflows, because a zero field is never decremented. All other bits pass through unmodified.
- U-turn drop:
  - Condition: computed port == IN_PORT and IN_PORT != PE.
  - The packet is popped but not enqueued. err_drop pulses in the cycle after the pop edge.
  - err_cnt increments and saturates at 2^CNT_W - 1.
  - PE-to-PE with zero hops is legal (self-delivery).
- Queue:
  - FIFO order. Each entry stores the updated packet plus the one-hot port.
  - busy = (count != 0).
  - out_req = head one-hot when count != 0, else 0.
  - out_req is registered-state-derived and never depends on out_ready.
  - out_packet = head packet. When the queue is empty, out_packet holds its last value.
- Transfer: occurs on an edge where (out_req & out_ready) != 0; the head is dequeued. Ready on non-requested bits is ignored.
- Latency: pop edge t; out_req asserted during cycle t+1. Minimum pass-through is 1 cycle.
- Throughput: with DEPTH = 2, enqueue and dequeue in the same cycle sustain 1 packet/cycle.
- Queue full (count = DEPTH): rd_en = 0 even if the head transfers this cycle. There is no bypass path.
- Back-pressure: out_req stays high and out_packet stays stable until ready. Request withdrawal is not permitted.
- Simultaneous push and dequeue: count is unchanged and order is preserved.
- Simultaneous pop of a dropped packet and dequeue: count decrements by 1.

Decomposition:
- Package noc_pkg:
  - Port index constants PORT_N = 0, PORT_S = 1, PORT_E = 2, PORT_W = 3, PORT_PE = 4, and NUM_PORTS = 5.
  - Default header field positions.
  - One-hot port typedef (5 bits).
- Sub-module xy_route_calc (purely combinational): header in -> one-hot port + updated header.
- The top level holds the queue, handshake logic, and drop counter.

Test Plan:
1. IN_PORT = N; packet with dir_x = 0, hop_x = 2, hop_y = 0; out_ready = 5'b11111 -> rd_en pulse; next cycle out_req = 5'b00100, out_packet[56:55] = 1; dequeued the same cycle.
2. IN_PORT = S; hop_x = 0, dir_y = 0, hop_y = 3 -> out_req = 5'b00001, out_packet[54:53] = 2. Then hop_x = 0, hop_y = 0 -> out_req = 5'b10000, header unchanged.
3. IN_PORT = E; dir_x = 0, hop_x = 1 (U-turn) -> popped, err_drop one cycle, err_cnt = 1, out_req stays 0. After 300 such packets with CNT_W = 8, err_cnt = 255.
4. DEPTH = 2; 8 back-to-back packets; out_ready = all ones -> rd_en high 8 consecutive cycles, 8 transfers on consecutive cycles, order preserved.
5. out_ready = 0 with 3 packets queued in FIFO -> after 2 pops rd_en = 0, out_req and out_packet stable for 10 cycles. Ready then raised -> transfers resume and the third packet is popped on the first dequeue-free slot.
6. Assert reset asynchronously mid-cycle with queue full -> out_req, busy and rd_en drop immediately without a clock edge. After release, a fresh packet routes normally with 1-cycle latency.
